// File: rtl/rules_grid_seq.sv
// rtl/rules_grid_seq.sv - sequential NTxND fuzzy rule-weight engine streaming firing strengths
// Optional PRODUCT_TNORM_EN selects the product t-norm instead of min.
module rules_grid_seq #(
    parameter int W  = 16,
    parameter int NT = 3,
    parameter int ND = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            corners_only,
    input  logic [NT*W-1:0]                 mu_t,
    input  logic [ND*W-1:0]                 mu_d,
    output logic                            busy,
    output logic                            w_valid,
    input  logic                            w_ready,
    output logic [W-1:0]                    w_data,
    output logic [$clog2(NT)-1:0]           w_idx_t,
    output logic [$clog2(ND)-1:0]           w_idx_d,
    output logic                            done,
    output logic [W+$clog2(NT*ND)-1:0]      w_sum,
    output logic [W-1:0]                    w_max
);

    localparam int TI = $clog2(NT);
    localparam int DI = $clog2(ND);
    localparam int SW = W + $clog2(NT*ND);
    localparam logic [TI-1:0] T_LAST = TI'(NT-1);
    localparam logic [DI-1:0] D_LAST = DI'(ND-1);
    localparam logic [TI-1:0] T_ONE  = TI'(1);
    localparam logic [DI-1:0] D_ONE  = DI'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    t_lat [NT];
    logic [W-1:0]    d_lat [ND];
    logic            corners_lat;
    logic [TI-1:0]   i_q;
    logic [DI-1:0]   j_q;
    logic [SW-1:0]   sum_q;
    logic [W-1:0]    max_q;
    logic            hs;
    logic            last_rule;
    logic            corner;
    logic [W-1:0]    and_val;
    logic [W-1:0]    rule_w;

`ifdef PRODUCT_TNORM_EN
    logic [2*W-1:0]  prod;
    // Q0.W x Q0.W gives Q0.2W; keep the upper half, truncated.
    assign prod    = {{W{1'b0}}, t_lat[i_q]} * {{W{1'b0}}, d_lat[j_q]};
    assign and_val = prod[2*W-1:W];
`else
    assign and_val = (t_lat[i_q] < d_lat[j_q]) ? t_lat[i_q] : d_lat[j_q];
`endif

    assign corner    = ((i_q == '0) || (i_q == T_LAST)) && ((j_q == '0) || (j_q == D_LAST));
    assign rule_w    = (corners_lat && !corner) ? '0 : and_val;
    assign last_rule = (i_q == T_LAST) && (j_q == D_LAST);
    assign hs        = (state == S_RUN) && w_ready;

    assign w_data  = (state == S_RUN) ? rule_w : '0;
    assign w_idx_t = i_q;
    assign w_idx_d = j_q;
    assign w_sum   = sum_q;
    assign w_max   = max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        w_valid  = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                w_valid = 1'b1;
                if (w_ready && last_rule) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NT; n++) t_lat[n] <= '0;
            for (int n = 0; n < ND; n++) d_lat[n] <= '0;
            corners_lat <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            sum_q       <= '0;
            max_q       <= '0;
        end else if ((state == S_IDLE) && start) begin
            for (int n = 0; n < NT; n++) t_lat[n] <= mu_t[n*W +: W];
            for (int n = 0; n < ND; n++) d_lat[n] <= mu_d[n*W +: W];
            corners_lat <= corners_only;
            i_q         <= '0;
            j_q         <= '0;
            sum_q       <= '0;
            max_q       <= '0;
        end else if (hs) begin
            sum_q <= sum_q + SW'(rule_w);
            if (rule_w > max_q) max_q <= rule_w;
            // Row-major walk; the final wrap leaves indices at (0,0) for idle.
            if (j_q == D_LAST) begin
                j_q <= '0;
                i_q <= (i_q == T_LAST) ? '0 : i_q + T_ONE;
            end else begin
                j_q <= j_q + D_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rules_grid_seq.sv
// tb/tb_rules_grid_seq.sv - scoreboard bench for rules_grid_seq (NT=ND=3, W=16)
module tb_rules_grid_seq;

    localparam int W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              corners_only = 1'b0;
    logic [3*W-1:0]    mu_t = '0;
    logic [3*W-1:0]    mu_d = '0;
    logic              busy, w_valid, done;
    logic              w_ready = 1'b1;
    logic [W-1:0]      w_data, w_max;
    logic [1:0]        w_idx_t, w_idx_d;
    logic [W+3:0]      w_sum;

    typedef struct { logic [15:0] data; logic [1:0] t; logic [1:0] d; } wexp_t;
    typedef struct { int cyc; logic [19:0] sum; logic [15:0] max; } dexp_t;

    wexp_t exp_w[$];
    dexp_t exp_d[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [1:0]  prev_t, prev_d;

    rules_grid_seq #(.W(W), .NT(3), .ND(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .corners_only(corners_only),
        .mu_t(mu_t), .mu_d(mu_d), .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_idx_t(w_idx_t), .w_idx_d(w_idx_d), .done(done),
        .w_sum(w_sum), .w_max(w_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] f_and(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
`ifdef PRODUCT_TNORM_EN
        p = {16'h0, a} * {16'h0, b};
        return p[31:16];
`else
        p = '0;
        return (a < b) ? a : b;
`endif
    endfunction

    // Monitor: pops the scoreboard on every handshake and every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_valid && prev_stall) begin
                chk("stall_data", w_data, prev_data);
                chk("stall_idx", {w_idx_t, w_idx_d}, {prev_t, prev_d});
            end
            if (w_valid && w_ready) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_weight", 1, 0);
                end else begin
                    wexp_t e;
                    e = exp_w.pop_front();
                    chk("w_data", w_data, e.data);
                    chk("w_idx", {w_idx_t, w_idx_d}, {e.t, e.d});
                end
            end
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
            prev_t     = w_idx_t;
            prev_d     = w_idx_d;
            if (done) begin
                done_cnt++;
                if (exp_d.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dexp_t e;
                    e = exp_d.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("w_sum", w_sum, e.sum);
                    chk("w_max", w_max, e.max);
                    chk("busy_in_done", busy, 0);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [19:0] pend_sum;
    logic [15:0] pend_max;

    task automatic push_grid(input logic [47:0] mt, input logic [47:0] md, input logic co);
        pend_sum = '0;
        pend_max = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wexp_t e;
                logic corner;
                corner = (i != 1) && (j != 1);
                e.data = (co && !corner) ? 16'h0 : f_and(mt[i*16 +: 16], md[j*16 +: 16]);
                e.t = 2'(i);
                e.d = 2'(j);
                exp_w.push_back(e);
                pend_sum += 20'(e.data);
                if (e.data > pend_max) pend_max = e.data;
            end
        end
    endtask

    // Issues start and returns the cycle count of the sampling edge.
    task automatic kick(input logic [47:0] mt, input logic [47:0] md, input logic co, output int s);
        @(posedge clk); #1;
        start = 1'b1; mu_t = mt; mu_d = md; corners_only = co;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
        mu_t = 48'hDEAD_BEEF_1234; mu_d = 48'h5555_AAAA_FFFF; corners_only = ~co;
        chk("busy_after_start", {busy, w_valid}, 2'b11);
    endtask

    task automatic expect_done(input int s, input int stalls);
        dexp_t e;
        e.cyc = s + 9 + stalls;
        e.sum = pend_sum;
        e.max = pend_max;
        exp_d.push_back(e);
    endtask

    task automatic wait_done(input int n);
        int budget;
        budget = 60;
        while (done_cnt < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (done_cnt < n) chk("done_timeout", done_cnt, n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [1:0] t, input logic [1:0] d);
        int budget;
        budget = 30;
        @(negedge clk);
        while (!(w_valid && w_idx_t == t && w_idx_d == d) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("wait_idx_timeout", {w_idx_t, w_idx_d}, {t, d});
    endtask

    int s;
    int n_done;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, w_valid, done, w_idx_t, w_idx_d}, 0);
        chk("reset_data", {w_data, w_sum, w_max}, 0);
        rst_n = 1'b1;
        n_done = 0;

        // Min full grid.
        push_grid({16'h4000, 16'h0000, 16'h4000}, {16'h2000, 16'h0000, 16'h2000}, 1'b0);
        kick({16'h4000, 16'h0000, 16'h4000}, {16'h2000, 16'h0000, 16'h2000}, 1'b0, s);
        expect_done(s, 0);
        wait_done(++n_done);
        chk("idle_after_done", {busy, w_valid, w_data}, 0);

        // Corners equivalence, full then corners-only.
        push_grid({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b0);
        kick({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b0, s);
        expect_done(s, 0);
        wait_done(++n_done);
        push_grid({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b1);
        kick({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b1, s);
        expect_done(s, 0);
        wait_done(++n_done);
        chk("sum_hold", w_sum, 20'h08000);

        // Backpressure on rule (1,1) for 3 cycles.
        push_grid({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b0);
        kick({16'h4000, 16'h8000, 16'h4000}, {16'h2000, 16'h6000, 16'h2000}, 1'b0, s);
        expect_done(s, 3);
        wait_idx(2'd1, 2'd0);
        @(posedge clk); #1;
        w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        w_ready = 1'b1;
        wait_done(++n_done);

        // Start while busy is ignored.
        push_grid({16'h4000, 16'h0000, 16'h4000}, {16'h2000, 16'h0000, 16'h2000}, 1'b0);
        kick({16'h4000, 16'h0000, 16'h4000}, {16'h2000, 16'h0000, 16'h2000}, 1'b0, s);
        expect_done(s, 0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; mu_t = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(++n_done);
        repeat (10) @(posedge clk);
        #1;
        chk("no_second_run", {busy, done_cnt[7:0]}, {1'b0, 8'(n_done)});

        // Asynchronous reset mid-run during rule (1,0).
        push_grid({16'hFFFF, 16'h1234, 16'h0100}, {16'h0FFF, 16'h8000, 16'hFFFF}, 1'b0);
        kick({16'hFFFF, 16'h1234, 16'h0100}, {16'h0FFF, 16'h8000, 16'hFFFF}, 1'b0, s);
        wait_idx(2'd1, 2'd0);
        #2;
        rst_n = 1'b0;
        exp_w.delete();
        #1;
        chk("abort_outs", {busy, w_valid, done, w_idx_t, w_idx_d}, 0);
        chk("abort_data", {w_data, w_sum, w_max}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("abort_no_done", done_cnt, n_done);

        // Fresh run after reset; also covers product vectors 4000x2000 and FFFFxFFFF.
        push_grid({16'hFFFF, 16'h1234, 16'h4000}, {16'hFFFF, 16'h8000, 16'h2000}, 1'b0);
        kick({16'hFFFF, 16'h1234, 16'h4000}, {16'hFFFF, 16'h8000, 16'h2000}, 1'b0, s);
        expect_done(s, 0);
        wait_done(++n_done);
        chk("queues_empty", exp_w.size() + exp_d.size(), 0);
        chk("done_total", done_cnt, n_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
